// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one variable-latency memory port between fetch (IF) and load/store (MEM).
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is data-over-fetch priority.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int STRB_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_kill,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [STRB_W-1:0] d_wstrb,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [STRB_W-1:0] mem_wstrb,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall_f,
   output logic              stall_m
);

   typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D, RESP} state_t;

   state_t              state_q, state_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                if_ready_q, if_ready_d;
   logic                d_ready_q, d_ready_d;
   logic                kill_q, kill_d;
   logic                grant_d, grant_f;

`ifdef MEM_ARB_RR_EN
   // 1 = data port was granted last; reset value points at fetch
   logic                last_d_q, last_d_d;

   always_comb begin
      grant_d = 1'b0;
      grant_f = 1'b0;
      if (state_q == IDLE) begin
         if (d_req && if_req) begin
            grant_d = ~last_d_q;
            grant_f = last_d_q;
         end else begin
            grant_d = d_req;
            grant_f = if_req;
         end
      end
   end

   always_comb begin
      last_d_d = last_d_q;
      if (grant_d)      last_d_d = 1'b1;
      else if (grant_f) last_d_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) last_d_q <= 1'b0;
      else        last_d_q <= last_d_d;
   end
`else
   always_comb begin
      grant_d = 1'b0;
      grant_f = 1'b0;
      if (state_q == IDLE) begin
         grant_d = d_req;
         grant_f = if_req & ~d_req;
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_ready_d  = 1'b0;
      d_ready_d   = 1'b0;
      kill_d      = kill_q;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_wstrb_d = d_we ? d_wstrb : '0;
               state_d     = BUSY_D;
            end else if (grant_f) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
               mem_wstrb_d = '0;
               kill_d      = if_kill;
               state_d     = BUSY_F;
            end
         end
         BUSY_F: begin
            if (if_kill) kill_d = 1'b1;
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = RESP;
               // a redirect in the ack cycle itself also discards the result
               if (!kill_q && !if_kill) begin
                  if_rdata_d = mem_rdata;
                  if_ready_d = 1'b1;
               end
            end
         end
         BUSY_D: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               d_ready_d = 1'b1;
               state_d   = RESP;
               if (!mem_we_q) d_rdata_d = mem_rdata;
            end
         end
         RESP: begin
            kill_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_ready_q  <= 1'b0;
         d_ready_q   <= 1'b0;
         kill_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_ready_q  <= if_ready_d;
         d_ready_q   <= d_ready_d;
         kill_q      <= kill_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_ready  = if_ready_q;
   assign d_ready   = d_ready_q;
   assign stall_f   = if_req & ~if_ready_q;
   assign stall_m   = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a latency-varying memory responder plus a word-level reference memory.
module tb_mem_port_arbiter;

   logic        clk, reset;
   logic        if_req, if_kill, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [3:0]  d_wstrb;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_ready, d_ready, mem_req, mem_we, mem_ack, stall_f, stall_m;
   logic [3:0]  mem_wstrb;

   int n_chk = 0;
   int n_pass = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STRB_W(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_rdata(if_rdata), .if_ready(if_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall_f(stall_f), .stall_m(stall_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // phys: what the memory actually holds; ref_mem: what the bench says it should hold
   logic [31:0] phys    [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   bit          last_data;
   int          force_lat = -1;
   int          mcnt, mlat;

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] phys_rd(input logic [31:0] a);
      return phys.exists(a) ? phys[a] : init_val(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
      logic [31:0] t;
      t = ref_rd(a);
      for (int i = 0; i < 4; i++) if (ws[i]) t[8*i +: 8] = wd[8*i +: 8];
      ref_mem[a] = t;
   endtask

   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         mem_ack = 1'b0;
         mcnt    = 0;
      end else begin
         mem_ack = 1'b0;
         if (mem_req) begin
            if (mcnt == 0) mlat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            if (mcnt >= mlat) begin
               mem_ack = 1'b1;
               mcnt    = 0;
               if (mem_we) begin
                  logic [31:0] t;
                  t = phys_rd(mem_addr);
                  for (int i = 0; i < 4; i++) if (mem_wstrb[i]) t[8*i +: 8] = mem_wdata[8*i +: 8];
                  phys[mem_addr] = t;
                  mem_rdata = $urandom;
               end else begin
                  mem_rdata = phys_rd(mem_addr);
               end
            end else begin
               mcnt++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_pair(input bit df, input bit dd, input bit we, input logic [31:0] fa,
                           input logic [31:0] da, input logic [31:0] wd, input logic [3:0] ws);
      bit f_done, d_done, exp_d_first;
      int f_at, d_at;
      logic [31:0] old_d, exp_f, exp_dd;
      old_d  = d_rdata;
      exp_f  = ref_rd(fa);
      exp_dd = we ? old_d : ref_rd(da);
      exp_d_first = 1'b1;
`ifdef MEM_ARB_RR_EN
      if (df && dd) exp_d_first = ~last_data;
`endif
      if_req = df; if_addr = fa;
      d_req = dd; d_we = we; d_addr = da; d_wdata = wd; d_wstrb = ws;
      f_done = !df; d_done = !dd; f_at = -1; d_at = -1;
      for (int c = 0; c < 80 && !(f_done && d_done); c++) begin
         tick();
         if (if_ready && df && !f_done) begin
            n_chk++;
            if (if_rdata !== exp_f) $display("FAIL pair_if_rdata addr=%h got=%h want=%h", fa, if_rdata, exp_f);
            else n_pass++;
            f_at = c; f_done = 1'b1; if_req = 1'b0;
         end
         if (d_ready && dd && !d_done) begin
            n_chk++;
            if (d_rdata !== exp_dd) $display("FAIL pair_d_rdata we=%0d addr=%h got=%h want=%h", we, da, d_rdata, exp_dd);
            else n_pass++;
            d_at = c; d_done = 1'b1; d_req = 1'b0;
            if (we) ref_write(da, wd, ws);
         end
      end
      n_chk++;
      if (!(f_done && d_done)) begin
         $display("FAIL pair_timeout f_done=%0d d_done=%0d want 1 1", f_done, d_done);
         if_req = 1'b0; d_req = 1'b0;
         repeat (20) tick();
      end else n_pass++;
      if (df && dd) begin
         n_chk++;
         if (d_at == f_at || ((d_at < f_at) != exp_d_first))
            $display("FAIL pair_order d_at=%0d f_at=%0d want data_first=%0d", d_at, f_at, exp_d_first);
         else n_pass++;
         last_data = !exp_d_first;
      end else begin
         last_data = dd;
      end
      tick();
   endtask

   task automatic test_reset();
      if_req = 0; if_kill = 0; d_req = 0; d_we = 0;
      if_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
      mem_rdata = 0; reset = 1'b0; last_data = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0)
         $display("FAIL reset_mem got req=%b we=%b addr=%h wd=%h ws=%h want all 0", mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
      else n_pass++;
      n_chk++;
      if ({if_ready, d_ready, if_rdata, d_rdata, stall_f, stall_m} !== '0)
         $display("FAIL reset_port got ifr=%b dr=%b ifd=%h dd=%h sf=%b sm=%b want all 0", if_ready, d_ready, if_rdata, d_rdata, stall_f, stall_m);
      else n_pass++;
      reset = 1'b1;
      tick();
   endtask

   task automatic test_fetch_basic();
      force_lat = 1;
      phys[32'h10] = 32'h0050_0093; ref_mem[32'h10] = 32'h0050_0093;
      if_req = 1'b1; if_addr = 32'h10;
      #1;
      n_chk++;
      if (stall_f !== 1'b1) $display("FAIL fetch_stall_c0 got=%b want=1", stall_f); else n_pass++;
      for (int c = 1; c <= 3; c++) begin
         tick();
         if (c == 1) begin
            n_chk++;
            if ({mem_req, mem_we, mem_wstrb, mem_addr} !== {1'b1, 1'b0, 4'h0, 32'h10})
               $display("FAIL fetch_issue got req=%b we=%b ws=%h addr=%h want 1 0 0 00000010", mem_req, mem_we, mem_wstrb, mem_addr);
            else n_pass++;
         end
         if (c < 3) begin
            n_chk++;
            if ({stall_f, if_ready} !== 2'b10) $display("FAIL fetch_wait c=%0d got stall=%b rdy=%b want 1 0", c, stall_f, if_ready);
            else n_pass++;
         end else begin
            n_chk++;
            if ({if_ready, stall_f, if_rdata} !== {1'b1, 1'b0, 32'h0050_0093})
               $display("FAIL fetch_done got rdy=%b stall=%b data=%h want 1 0 00500093", if_ready, stall_f, if_rdata);
            else n_pass++;
         end
      end
      if_req = 1'b0;
      tick();
      n_chk++;
      if ({if_ready, mem_req} !== 2'b00) $display("FAIL fetch_pulse got rdy=%b req=%b want 0 0", if_ready, mem_req);
      else n_pass++;
      last_data = 1'b0;
      force_lat = -1;
   endtask

   task automatic test_simultaneous();
      force_lat = 1;
      run_pair(1, 1, 0, 32'h14, 32'h2000, 32'h0, 4'h0);
`ifdef MEM_ARB_RR_EN
      run_pair(0, 1, 0, 32'h0, 32'h2000, 32'h0, 4'h0);
      run_pair(1, 1, 0, 32'h18, 32'h2000, 32'h0, 4'h0);
`endif
      force_lat = -1;
   endtask

   task automatic test_store();
      logic [31:0] old_d;
      int pulses, busy;
      force_lat = 4;
      old_d = d_rdata; pulses = 0; busy = 0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
      for (int c = 0; c < 14; c++) begin
         tick();
         if (mem_req) begin
            busy++;
            n_chk++;
            if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011})
               $display("FAIL store_hold c=%0d got we=%b addr=%h wd=%h ws=%b want 1 00002004 deadbeef 0011", c, mem_we, mem_addr, mem_wdata, mem_wstrb);
            else n_pass++;
         end
         if (d_ready) begin
            pulses++;
            d_req = 1'b0;
            n_chk++;
            if (d_rdata !== old_d) $display("FAIL store_rdata got=%h want=%h", d_rdata, old_d); else n_pass++;
         end
      end
      n_chk++;
      if (pulses != 1 || busy != 5) $display("FAIL store_count got pulses=%0d busy=%0d want 1 5", pulses, busy);
      else n_pass++;
      ref_write(32'h2004, 32'hDEAD_BEEF, 4'b0011);
      last_data = 1'b1;
      d_we = 1'b0;
      force_lat = -1;
      run_pair(0, 1, 0, 32'h0, 32'h2004, 32'h0, 4'h0);
   endtask

   task automatic test_kill();
      logic [31:0] old_f;
      int pulses;
      bit dropped;
      force_lat = 3;
      phys[32'h40] = 32'h1111_2222; ref_mem[32'h40] = 32'h1111_2222;
      old_f = if_rdata; pulses = 0; dropped = 1'b0;
      if_req = 1'b1; if_addr = 32'h40;
      tick();
      n_chk++;
      if (mem_req !== 1'b1) $display("FAIL kill_issue got req=%b want 1", mem_req); else n_pass++;
      if_kill = 1'b1;
      tick();
      if_kill = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (if_ready) pulses++;
         if (!mem_req && !dropped) begin
            dropped = 1'b1;
            if_req = 1'b0;
         end
      end
      n_chk++;
      if (pulses != 0 || !dropped || if_rdata !== old_f)
         $display("FAIL kill_discard got pulses=%0d acked=%0d rdata=%h want 0 1 %h", pulses, dropped, if_rdata, old_f);
      else n_pass++;
      if_req = 1'b0;
      last_data = 1'b0;
      force_lat = -1;
      run_pair(1, 0, 0, 32'h40, 32'h0, 32'h0, 4'h0);
   endtask

   task automatic test_reset_busy();
      force_lat = 8;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2008;
      tick();
      tick();
      n_chk++;
      if (mem_req !== 1'b1) $display("FAIL rstbusy_issue got req=%b want 1", mem_req); else n_pass++;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      n_chk++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_rdata, d_rdata, if_ready, d_ready} !== '0)
         $display("FAIL rstbusy_clear got req=%b addr=%h ifd=%h dd=%h want all 0", mem_req, mem_addr, if_rdata, d_rdata);
      else n_pass++;
      d_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      last_data = 1'b0;
      force_lat = -1;
      tick();
      n_chk++;
      if (mem_req !== 1'b0) $display("FAIL rstbusy_idle got req=%b want 0", mem_req); else n_pass++;
      run_pair(0, 1, 0, 32'h0, 32'h2008, 32'h0, 4'h0);
   endtask

   task automatic test_back_to_back();
      int k, extra;
      bit post;
      logic [31:0] a;
      k = 0; extra = 0; post = 1'b0;
      a = 32'h2010;
      d_req = 1'b1; d_we = 1'b0; d_addr = a;
      for (int c = 0; c < 100 && k < 4; c++) begin
         tick();
         if (post) begin
            post = 1'b0;
            n_chk++;
            if (mem_req !== 1'b0) $display("FAIL b2b_regrant k=%0d got req=%b want 0", k, mem_req); else n_pass++;
         end
         if (d_ready) begin
            n_chk++;
            if (d_rdata !== ref_rd(a)) $display("FAIL b2b_data k=%0d got=%h want=%h", k, d_rdata, ref_rd(a));
            else n_pass++;
            k++;
            post = 1'b1;
            if (k < 4) begin
               a = a + 32'h4;
               d_addr = a;
            end else d_req = 1'b0;
         end
      end
      for (int c = 0; c < 6; c++) begin
         tick();
         if (d_ready) extra++;
      end
      n_chk++;
      if (k != 4 || extra != 0) $display("FAIL b2b_count got done=%0d extra=%0d want 4 0", k, extra);
      else n_pass++;
      last_data = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         int op;
         logic [31:0] fa, da;
         op = int'($urandom_range(0, 4));
         fa = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
         da = 32'h2000 + {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         case (op)
            0: run_pair(1, 0, 0, fa, da, 32'h0, 4'h0);
            1: run_pair(0, 1, 0, fa, da, 32'h0, 4'h0);
            2: run_pair(0, 1, 1, fa, da, $urandom, 4'($urandom_range(0, 15)));
            3: run_pair(1, 1, 0, fa, da, 32'h0, 4'h0);
            default: run_pair(1, 1, 1, fa, da, $urandom, 4'($urandom_range(0, 15)));
         endcase
      end
   endtask

   initial begin
      test_reset();
      test_fetch_basic();
      test_simultaneous();
      test_store();
      test_kill();
      test_reset_busy();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
